multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/riscv_ctrl_pkg.sv | 37 +++
 rtl/ctrl_decode.sv | 48 ++++
 rtl/multicycle_ctrl.sv | 138 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding,
// ALUOp encodings, supported opcodes and the opcode legality check.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_CMP   = 2'b01,
        ALU_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // True for the opcodes this controller knows how to sequence.
    function automatic logic op_legal(input logic [6:0] op);
        logic ok;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: ok = 1'b1;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Per-opcode control field decode used in EXEC/MEM/WB, driven by the
// opcode latched during DECODE.
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op_q,
    output aluop_t     alu_op,
    output logic       alu_src,
    output logic       is_branch,
    output logic       is_load,
    output logic       is_store
);

    // Map the latched opcode onto ALU control and instruction class flags.
    always_comb begin
        alu_op    = ALU_ADD;
        alu_src   = 1'b0;
        is_branch = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        case (op_q)
            OP_R: begin
                alu_op  = ALU_FUNCT;
                alu_src = 1'b0;
            end
            OP_I: begin
                alu_op  = ALU_FUNCT;
                alu_src = 1'b1;
            end
            OP_LOAD: begin
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
                is_load = 1'b1;
            end
            OP_STORE: begin
                alu_op   = ALU_ADD;
                alu_src  = 1'b1;
                is_store = 1'b1;
            end
            OP_BRANCH: begin
                alu_op    = ALU_CMP;
                is_branch = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: FETCH / DECODE / EXEC / MEM / WB with a
// sticky TRAP for unsupported opcodes. Outputs are decoded from the state
// and the latched opcode; memory handshakes complete on mem_ready.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter bit RESET_IDLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       MemtoReg,
    output logic       ALUScr,
    output logic       RegWrite,
    output logic [1:0] ALUOp_out,
    output logic       retire,
    output logic       illegal
);

    state_t     state;
    logic [6:0] op_q;

    aluop_t dec_alu_op;
    logic   dec_alu_src;
    logic   dec_is_branch;
    logic   dec_is_load;
    logic   dec_is_store;

    ctrl_decode u_decode (
        .op_q      (op_q),
        .alu_op    (dec_alu_op),
        .alu_src   (dec_alu_src),
        .is_branch (dec_is_branch),
        .is_load   (dec_is_load),
        .is_store  (dec_is_store)
    );

    // State sequencing and opcode latch; completed instructions continue to
    // FETCH only while run is high, otherwise the controller parks in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (RESET_IDLE) state <= ST_IDLE;
            else            state <= ST_FETCH;
            op_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem_ready) state <= ST_DECODE;
                end
                ST_DECODE: begin
                    op_q <= opcode;
                    if (op_legal(opcode)) state <= ST_EXEC;
                    else                  state <= ST_TRAP;
                end
                ST_EXEC: begin
                    if (dec_is_branch) begin
                        if (run) state <= ST_FETCH;
                        else     state <= ST_IDLE;
                    end else if (dec_is_load || dec_is_store) begin
                        state <= ST_MEM;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (dec_is_load) state <= ST_WB;
                        else if (run)    state <= ST_FETCH;
                        else             state <= ST_IDLE;
                    end
                end
                ST_WB: begin
                    if (run) state <= ST_FETCH;
                    else     state <= ST_IDLE;
                end
                ST_TRAP: state <= ST_TRAP;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output decode; gated by rst_n so everything is low while reset is held,
    // including when the reset state is FETCH.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        branch    = 1'b0;
        MemtoReg  = 1'b0;
        ALUScr    = 1'b0;
        RegWrite  = 1'b0;
        ALUOp_out = '0;
        retire    = 1'b0;
        illegal   = 1'b0;
        if (rst_n) begin
            case (state)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                ST_EXEC: begin
                    ALUOp_out = dec_alu_op;
                    ALUScr    = dec_alu_src;
                    branch    = dec_is_branch;
                    retire    = dec_is_branch;
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = dec_is_store;
                    retire   = dec_is_store & mem_ready;
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = dec_is_load;
                    retire   = 1'b1;
                end
                ST_TRAP: illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes the expected
// per-instruction profile computed from latency/behaviour rules, a memory
// responder inserts wait cycles, and a monitor accumulates what the DUT did
// between fetch start and retire and compares at each retire.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [6:0] opcode;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, addr_sel, ir_write, pc_write;
    logic       branch, MemtoReg, ALUScr, RegWrite;
    logic [1:0] ALUOp_out;
    logic       retire, illegal;

    multicycle_ctrl #(.RESET_IDLE(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .branch    (branch),
        .MemtoReg  (MemtoReg),
        .ALUScr    (ALUScr),
        .RegWrite  (RegWrite),
        .ALUOp_out (ALUOp_out),
        .retire    (retire),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned lat;
        int unsigned mreq_f;
        int unsigned mreq_m;
        int unsigned we;
        int unsigned rw;
        int unsigned m2r;
        int unsigned br;
        int unsigned asrc;
        int unsigned aluop;
    } exp_t;

    exp_t        sb[$];
    int unsigned waitq[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] outs();
        return {mem_req, mem_we, addr_sel, ir_write, pc_write, branch, MemtoReg,
                ALUScr, RegWrite, ALUOp_out, retire, illegal};
    endfunction

    function automatic bit is_mem_op(input logic [6:0] op);
        return (op == OPC_LOAD) || (op == OPC_STORE);
    endfunction

    // Expected instruction profile from the latency table and per-class rules.
    function automatic exp_t model(input logic [6:0] op, input int unsigned fw, input int unsigned mw);
        exp_t e;
        int unsigned base;
        case (op)
            OPC_LOAD:   base = 5;
            OPC_BRANCH: base = 3;
            default:    base = 4;
        endcase
        e.lat    = base + fw + (is_mem_op(op) ? mw : 0);
        e.mreq_f = fw + 1;
        e.mreq_m = is_mem_op(op) ? mw + 1 : 0;
        e.we     = (op == OPC_STORE) ? mw + 1 : 0;
        e.rw     = (op == OPC_R || op == OPC_I || op == OPC_LOAD) ? 1 : 0;
        e.m2r    = (op == OPC_LOAD) ? 1 : 0;
        e.br     = (op == OPC_BRANCH) ? 1 : 0;
        e.asrc   = (op == OPC_I || is_mem_op(op)) ? 1 : 0;
        e.aluop  = (op == OPC_R || op == OPC_I) ? 2 : (op == OPC_BRANCH) ? 1 : 0;
        return e;
    endfunction

    // Memory responder: each new request takes its wait count from waitq;
    // while no request is pending mem_ready toggles randomly (must be ignored).
    int unsigned mcnt = 0;
    bit          mbusy = 1'b0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbusy     = 1'b0;
            mem_ready = 1'b0;
        end else if (mem_req) begin
            if (!mbusy) begin
                mbusy = 1'b1;
                mcnt  = (waitq.size() > 0) ? waitq.pop_front() : 0;
            end
            if (mcnt == 0) begin
                mem_ready = 1'b1;
                mbusy     = 1'b0;
            end else begin
                mem_ready = 1'b0;
                mcnt--;
            end
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: accumulate activity from fetch start to retire, compare on retire.
    bit          in_instr = 1'b0;
    int unsigned c_lat, c_mf, c_mm, c_we, c_webad, c_rw, c_m2r, c_irw, c_pcw, c_br, c_asrc, c_alu;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                in_instr = 1'b0;
                continue;
            end
            if (!in_instr && mem_req && !addr_sel) begin
                in_instr = 1'b1;
                c_lat = 0; c_mf = 0; c_mm = 0; c_we = 0; c_webad = 0; c_rw = 0;
                c_m2r = 0; c_irw = 0; c_pcw = 0; c_br = 0; c_asrc = 0; c_alu = 0;
            end
            if (in_instr) begin
                c_lat++;
                if (mem_req && !addr_sel) c_mf++;
                if (mem_req && addr_sel)  c_mm++;
                if (mem_we)               c_we++;
                if (mem_we && !(mem_req && addr_sel)) c_webad++;
                if (RegWrite) c_rw++;
                if (MemtoReg) c_m2r++;
                if (ir_write) c_irw++;
                if (pc_write) c_pcw++;
                if (branch)   c_br++;
                if (ALUScr)   c_asrc++;
                c_alu = c_alu | 32'(ALUOp_out);
                if (retire) begin
                    check("expectation_available", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("latency",        c_lat,   e.lat);
                        check("mem_req_fetch",  c_mf,    e.mreq_f);
                        check("mem_req_mem",    c_mm,    e.mreq_m);
                        check("mem_we_cycles",  c_we,    e.we);
                        check("mem_we_outside", c_webad, 0);
                        check("regwrite",       c_rw,    e.rw);
                        check("memtoreg",       c_m2r,   e.m2r);
                        check("ir_write",       c_irw,   1);
                        check("pc_write",       c_pcw,   1);
                        check("branch",         c_br,    e.br);
                        check("alusrc",         c_asrc,  e.asrc);
                        check("aluop",          c_alu,   e.aluop);
                    end
                    in_instr = 1'b0;
                end
            end else begin
                check("retire_outside_instr", 32'(retire), 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("outputs_in_reset", 32'(outs()), 0);
        sb.delete();
        waitq.delete();
        run = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_req && !addr_sel) begin
                ok = 1'b1;
                break;
            end
        end
        check("fetch_start", 32'(ok), 1);
    endtask

    task automatic issue(input logic [6:0] op, input int unsigned fw, input int unsigned mw, input bit drop);
        bit          ok;
        int unsigned bad;
        sb.push_back(model(op, fw, mw));
        waitq.push_back(fw);
        if (is_mem_op(op)) waitq.push_back(mw);
        opcode = op;
        run    = 1'b1;
        wait_fetch(ok);
        if (!ok) begin
            do_reset();
            return;
        end
        if (drop) begin
            repeat ($urandom_range(0, 1)) tick();
            run = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (retire) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("retire_seen", 32'(ok), 1);
        if (!ok) begin
            do_reset();
            return;
        end
        if (drop) begin
            bad = 0;
            repeat (5) begin
                tick();
                if (mem_req) bad++;
            end
            check("parked_no_mem_req", bad, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  ops[5];
        logic [6:0]  op;
        int unsigned fw;
        int unsigned bad;
        int unsigned n;
        bit          ok;

        ops = '{OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH};
        rst_n  = 1'b0;
        run    = 1'b0;
        opcode = '0;
        repeat (2) tick();
        check("reset_outputs", 32'(outs()), 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            tick();
            if (outs() != '0) bad++;
        end
        check("idle_outputs", bad, 0);

        // Directed instructions: zero-wait R, LOAD with 2+2 waits, STORE, BRANCH, I with run dropped.
        issue(OPC_R, 0, 0, 1'b0);
        issue(OPC_LOAD, 2, 2, 1'b0);
        issue(OPC_STORE, 0, 1, 1'b0);
        issue(OPC_BRANCH, 1, 0, 1'b0);
        issue(OPC_I, 0, 0, 1'b1);
        issue(OPC_LOAD, 0, 0, 1'b1);

        repeat (60) begin
            issue(ops[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0));
        end
        issue(OPC_BRANCH, 0, 0, 1'b1);

        // Reset in the middle of a fetch wait: mem_req must drop at once, no retire.
        sb.push_back(model(OPC_R, 6, 0));
        waitq.push_back(6);
        opcode = OPC_R;
        run    = 1'b1;
        wait_fetch(ok);
        tick();
        tick();
        check("mem_req_before_reset", 32'(mem_req), 1);
        run = 1'b0;
        do_reset();
        bad = 0;
        repeat (4) begin
            tick();
            if (mem_req) bad++;
        end
        check("idle_after_reset", bad, 0);

        // Illegal opcode: trap after decode, hold with run high, cleared by reset.
        do begin
            op = 7'($urandom_range(0, 127));
        end while (op inside {OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH});
        fw = $urandom_range(0, 2);
        waitq.push_back(fw);
        opcode = op;
        run    = 1'b1;
        wait_fetch(ok);
        n = 1;
        while (!illegal && n < 30) begin
            tick();
            n++;
        end
        check("trap_cycle", n, fw + 3);
        bad = 0;
        repeat (100) begin
            tick();
            if (outs() != 13'h001) bad++;
        end
        check("trap_hold", bad, 0);
        rst_n = 1'b0;
        #1;
        check("illegal_cleared", 32'(illegal), 0);
        run = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("illegal_after_release", 32'(illegal), 0);

        // Machine still works after the trap is cleared.
        issue(OPC_STORE, 1, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
